// File: rtl/sos_cascade_ctrl.sv
// Sequencer for a cascade of biquad sections: latches one sample, triggers each
// section in turn, waits for its done, then captures the chain output.
module sos_cascade_ctrl #(
  parameter int NUM_SECTIONS = 4,
  parameter int DATA_SIZE    = 24,
  parameter int TIMEOUT      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_trig,
  input  logic [DATA_SIZE-1:0]    data_in,
  output logic [DATA_SIZE-1:0]    sample_hold,
  output logic [NUM_SECTIONS-1:0] sec_trig,
  input  logic [NUM_SECTIONS-1:0] sec_done,
  input  logic [DATA_SIZE-1:0]    last_data,
  output logic [DATA_SIZE-1:0]    data_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    err_overrun,
  output logic                    err_timeout,
  input  logic                    err_clr
);

  localparam int KW = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_SECTIONS - 1);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT, FINISH} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic          accept, overrun_evt, timeout_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      k           <= '0;
      cnt         <= '0;
      sample_hold <= '0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      cnt       <= cnt_nxt;
      out_valid <= (state == FINISH);
      if (accept)
        sample_hold <= data_in;
      if (state == FINISH)
        data_out <= last_data;
      err_overrun <= overrun_evt | (err_overrun & ~err_clr);
      err_timeout <= timeout_evt | (err_timeout & ~err_clr);
    end
  end

  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    cnt_nxt     = cnt;
    accept      = 1'b0;
    timeout_evt = 1'b0;
    sec_trig    = '0;
    busy        = (state != IDLE);
    overrun_evt = sample_trig && ((state == TRIG) || (state == WAIT));
    case (state)
      IDLE: begin
        if (sample_trig) begin
          accept    = 1'b1;
          k_nxt     = '0;
          state_nxt = TRIG;
        end
      end
      TRIG: begin
        sec_trig[k] = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (sec_done[k]) begin
          if (k == K_LAST) begin
            state_nxt = FINISH;
          end else begin
            k_nxt     = k + 1'b1;
            state_nxt = TRIG;
          end
        end else if (cnt == CNT_LAST) begin
          timeout_evt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      FINISH: begin
        // The output capture is registered, so FINISH can already take the next
        // sample; this gives the 3N+1 minimum sample period.
        if (sample_trig) begin
          accept    = 1'b1;
          k_nxt     = '0;
          state_nxt = TRIG;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sos_cascade_ctrl.sv
// Randomized bench for sos_cascade_ctrl against an edge-timeline reference model
// with simple 2-cycle section models, optional hung section and spurious dones.
module tb_sos_cascade_ctrl;
  localparam int N  = 4;
  localparam int DW = 24;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst, sample_trig, err_clr;
  logic [DW-1:0] data_in, last_data, sample_hold, data_out;
  logic [N-1:0]  sec_trig, sec_done, spur, d1, d2, hmask;
  logic          out_valid, busy, err_overrun, err_timeout;

  int n_chk = 0;
  int n_err = 0;
  int hang_sec = -1;
  bit spur_en = 1'b0;
  bit chk_en = 1'b0;

  // reference model: timeline relative to the accepting edge
  int            cyc, m_s, m_hang, rel;
  bit            m_active, was_active, fin, tmo, ovr;
  logic [DW-1:0] exp_hold, exp_dout;
  bit            exp_valid, exp_ov, exp_to;

  logic [N-1:0]  exp_trig;
  int            cr, ck;

  always #5 clk = ~clk;

  sos_cascade_ctrl #(.NUM_SECTIONS(N), .DATA_SIZE(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst), .sample_trig(sample_trig), .data_in(data_in),
    .sample_hold(sample_hold), .sec_trig(sec_trig), .sec_done(sec_done),
    .last_data(last_data), .data_out(data_out), .out_valid(out_valid),
    .busy(busy), .err_overrun(err_overrun), .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  // section models: done two cycles after trigger, unless hung
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= sec_trig;
      d2 <= d1;
    end
  end

  always_comb begin
    hmask = '0;
    if (m_hang >= 0 && m_hang < N) hmask[m_hang] = 1'b1;
    sec_done = (d2 & ~hmask) | spur;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0; m_hang = -1; m_s = 0; cyc = 0;
      exp_hold = '0; exp_dout = '0; exp_valid = 1'b0; exp_ov = 1'b0; exp_to = 1'b0;
    end else begin
      rel        = cyc - m_s;
      was_active = m_active;
      fin        = m_active && m_hang < 0 && rel == 3 * N + 1;
      tmo        = m_active && m_hang >= 0 && rel == 3 * m_hang + 1 + TO;
      ovr        = 1'b0;
      exp_valid  = 1'b0;
      if (fin) begin
        exp_dout  = last_data;
        exp_valid = 1'b1;
      end
      if (fin || tmo) m_active = 1'b0;
      if (sample_trig) begin
        if (!was_active || fin) begin
          m_active = 1'b1;
          m_s      = cyc;
          m_hang   = hang_sec;
          exp_hold = data_in;
        end else begin
          ovr = 1'b1;
        end
      end
      exp_ov = ovr | (exp_ov & ~err_clr);
      exp_to = tmo | (exp_to & ~err_clr);
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      exp_trig = '0;
      if (m_active) begin
        cr = cyc - 1 - m_s;
        ck = cr / 3;
        if (cr % 3 == 0 && ck < N && (m_hang < 0 || ck <= m_hang)) exp_trig[ck] = 1'b1;
      end
      chk("sec_trig", 64'(sec_trig), 64'(exp_trig));
      chk("busy", 64'(busy), 64'(m_active));
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("data_out", 64'(data_out), 64'(exp_dout));
      chk("sample_hold", 64'(sample_hold), 64'(exp_hold));
      chk("err_overrun", 64'(err_overrun), 64'(exp_ov));
      chk("err_timeout", 64'(err_timeout), 64'(exp_to));
    end
  end

  task automatic step(input bit trig, input logic [DW-1:0] din, input bit clr);
    int r, wk;
    @(negedge clk);
    sample_trig = trig;
    data_in     = din;
    err_clr     = clr;
    spur        = '0;
    if (spur_en) begin
      spur = N'($urandom);
      if (m_active) begin
        r  = cyc - 1 - m_s;
        wk = r / 3;
        if (m_hang >= 0 && wk > m_hang) wk = m_hang;
        if (wk < N) spur[wk] = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, DW'($urandom), 1'b0);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    sample_trig = 1'b0;
    err_clr     = 1'b0;
    spur        = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_sec_trig", 64'(sec_trig), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_sample_hold", 64'(sample_hold), 64'd0);
    chk("rst_err_overrun", 64'(err_overrun), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sample_trig = 1'b0; err_clr = 1'b0; data_in = '0;
    last_data = 24'hABCDEF; spur = '0;
    #2 rst = 1'b1;
    #1;
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_sec_trig", 64'(sec_trig), 64'd0);
    chk("init_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    // basic pass
    step(1'b1, 24'h123456, 1'b0);
    idle(16);
    // overrun at E5, then clear
    step(1'b1, 24'h123456, 1'b0);
    idle(4);
    step(1'b1, 24'h000001, 1'b0);
    idle(10);
    step(1'b0, 24'h0, 1'b1);
    idle(2);
    // section 2 hangs, then a clean sample
    hang_sec = 2;
    step(1'b1, 24'h0A0B0C, 1'b0);
    idle(20);
    hang_sec = -1;
    step(1'b1, 24'h111111, 1'b1);
    idle(16);
    // spurious dones on non-waited sections
    spur_en = 1'b1;
    step(1'b1, 24'h222222, 1'b0);
    idle(16);
    spur_en = 1'b0;
    // back-to-back at E13, then an early trigger at E12
    step(1'b1, 24'h333333, 1'b0);
    idle(12);
    step(1'b1, 24'h444444, 1'b0);
    idle(11);
    step(1'b1, 24'h555555, 1'b0);
    idle(16);
    // reset mid-sequence, then a new sample
    step(1'b1, 24'h666666, 1'b0);
    idle(6);
    rst_pulse();
    step(1'b1, 24'h777777, 1'b0);
    idle(16);

    spur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        hang_sec = int'($urandom_range(0, 11));
        if (hang_sec >= N) hang_sec = -1;
      end
      if ($urandom_range(0, 399) == 0) begin
        rst_pulse();
      end else begin
        step($urandom_range(0, 9) == 0, DW'($urandom), $urandom_range(0, 15) == 0);
        last_data = DW'($urandom);
      end
    end
    spur_en  = 1'b0;
    hang_sec = -1;
    idle(30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
